// File: rtl/maxpool_stream_2x2.sv
// ----------------------------------------------------------------------------
// maxpool_stream_2x2
//
// Streaming 2x2 max-pool. Each input beat carries LANES signed elements of
// one feature-map row. Even rows are reduced horizontally (pairs of adjacent
// lanes) and parked in a line buffer. Odd rows are reduced the same way and
// then combined with the buffered entry for the same beat position. This
// yields LANES/2 pooled elements per odd-row beat, optionally clamped at zero.
//
// Ports
//   clk        : single clock
//   rst_n      : synchronous active-low reset
//   cfg_beats  : beats per row (0 or > MAX_BEATS means MAX_BEATS)
//   cfg_relu   : clamp negative results to zero
//   in_valid   : input beat valid
//   in_ready   : input beat accepted when in_valid && in_ready
//   in_data    : LANES elements, lane j at [DATA_W*(j+1)-1 : DATA_W*j]
//   in_last    : final beat of the frame
//   out_valid  : output beat valid
//   out_ready  : output beat consumed when out_valid && out_ready
//   out_data   : LANES/2 pooled elements, lane k at [DATA_W*(k+1)-1 : DATA_W*k]
//   out_last   : final output beat of the frame
//   err        : sticky flag, in_last seen on a beat that cannot end a frame
//
// State table
//   ROW_A | buffering an even row (horizontal max into line buffer)
//   ROW_B | combining an odd row with the buffer, producing output beats
// ----------------------------------------------------------------------------
module maxpool_stream_2x2 #(
    parameter int DATA_W    = 16,
    parameter int LANES     = 12,
    parameter int MAX_BEATS = 8,
    parameter int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BEAT_W-1:0]           cfg_beats,
    input  logic                        cfg_relu,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_W-1:0]     in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES/2*DATA_W-1:0]   out_data,
    output logic                        out_last,
    output logic                        err
);

    localparam int HALF  = LANES / 2;
    localparam int OUT_W = HALF * DATA_W;
    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic {
        ROW_A = 1'b0,
        ROW_B = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    cnt;
    logic [BEAT_W-1:0]   beats_q;

    // Line buffer: one horizontally reduced even-row beat per entry.
    // Deliberately not reset; an entry is always written in ROW_A before the
    // matching ROW_B beat reads it.
    logic [OUT_W-1:0]    line_buf [MAX_BEATS];

    logic                accept;
    logic [BEAT_W-1:0]   eff_beats;
    logic [BEAT_W-1:0]   row_beats;
    logic                final_beat;
    logic [OUT_W-1:0]    h_row;
    logic [OUT_W-1:0]    buf_rd;
    logic [OUT_W-1:0]    pooled;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DATA_W-1:0] relu_clamp(
        input logic signed [DATA_W-1:0] v,
        input logic                     relu
    );
        return (relu && v[DATA_W-1]) ? '0 : v;
    endfunction

    // in_ready depends only on state and the output register, never on in_valid.
    // ROW_A beats never produce output, so they are taken even under a stall.
    assign in_ready = (state == ROW_A) || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        eff_beats = cfg_beats;
        if ((cfg_beats == '0) || (cfg_beats > BEAT_W'(MAX_BEATS))) begin
            eff_beats = BEAT_W'(MAX_BEATS);
        end
    end

    // beats_q is only loaded on the first ROW_A beat, so that beat must use
    // the live configuration to decide whether it already ends the row.
    always_comb begin
        row_beats = beats_q;
        if ((state == ROW_A) && (cnt == '0)) begin
            row_beats = eff_beats;
        end
        final_beat = (BEAT_W'(cnt) == (row_beats - BEAT_W'(1)));
    end

    assign buf_rd = line_buf[cnt];

    always_comb begin
        h_row  = '0;
        pooled = '0;
        for (int k = 0; k < HALF; k++) begin
            h_row[k*DATA_W +: DATA_W] = smax(in_data[(2*k)*DATA_W +: DATA_W],
                                             in_data[(2*k+1)*DATA_W +: DATA_W]);
            pooled[k*DATA_W +: DATA_W] =
                relu_clamp(smax(buf_rd[k*DATA_W +: DATA_W], h_row[k*DATA_W +: DATA_W]),
                           cfg_relu);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept && (state == ROW_A)) begin
            line_buf[cnt] <= h_row;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ROW_A;
            cnt       <= '0;
            beats_q   <= BEAT_W'(MAX_BEATS);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                if ((state == ROW_A) && (cnt == '0)) begin
                    beats_q <= eff_beats;
                end
                if (final_beat) begin
                    cnt   <= '0;
                    state <= (state == ROW_A) ? ROW_B : ROW_A;
                end else begin
                    cnt <= cnt + IDX_W'(1);
                end
                // in_last may only close a frame on the final ROW_B beat.
                if (in_last && !((state == ROW_B) && final_beat)) begin
                    err <= 1'b1;
                end
            end

            if (accept && (state == ROW_B)) begin
                out_valid <= 1'b1;
                out_data  <= pooled;
                out_last  <= in_last && final_beat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_stream_2x2.sv
module tb_maxpool_stream_2x2;

    localparam int DATA_W    = 16;
    localparam int LANES     = 12;
    localparam int HALF      = LANES / 2;
    localparam int MAX_BEATS = 8;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam int IN_W      = LANES * DATA_W;
    localparam int OUT_W     = HALF * DATA_W;

    logic                clk;
    logic                rst_n;
    logic [BEAT_W-1:0]   cfg_beats;
    logic                cfg_relu;
    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic                out_last;
    logic                err;

    maxpool_stream_2x2 #(
        .DATA_W    (DATA_W),
        .LANES     (LANES),
        .MAX_BEATS (MAX_BEATS),
        .BEAT_W    (BEAT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_beats (cfg_beats),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
    } exp_t;

    exp_t             exp_q[$];
    int               n_chk;
    int               n_pass;
    int               n_pop;
    logic [OUT_W-1:0] last_out;
    logic             stall_prev;
    logic [OUT_W-1:0] held_prev;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: a transfer happens at the next rising edge whenever
    // out_valid && out_ready is seen at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_last", out_last, e.l);
                n_pop++;
                last_out = out_data;
            end
        end
        if (rst_n && stall_prev && out_valid) begin
            chk("stall_hold_data", out_data, held_prev);
        end
        stall_prev = rst_n && out_valid && !out_ready;
        held_prev  = out_data;
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drive_beat(input logic [IN_W-1:0] d, input logic l);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // pattern: 0 random, 1 ramp (A = j, B = 11-j), 2 A = 0x8000 / B = 0xFFFF.
    // bad_last: global beat index on which an extra in_last is pulsed (-1 none).
    // send_limit: number of beats actually sent (-1 for the whole frame).
    task automatic run_frame(input int beats_cfg, input int nrows, input logic relu,
                             input int pattern, input int bad_last, input int send_limit);
        int          rows [0:3][0:7][0:LANES-1];
        int          nb;
        int          total;
        int          limit;
        int          mx;
        int          g;
        logic [15:0] r16;
        logic [IN_W-1:0] d;
        exp_t        e;

        nb    = (beats_cfg == 0 || beats_cfg > MAX_BEATS) ? MAX_BEATS : beats_cfg;
        total = nb * nrows;
        limit = (send_limit < 0) ? total : send_limit;
        cfg_beats = BEAT_W'(beats_cfg);
        cfg_relu  = relu;

        for (int r = 0; r < nrows; r++) begin
            for (int b = 0; b < nb; b++) begin
                for (int j = 0; j < LANES; j++) begin
                    case (pattern)
                        1: rows[r][b][j] = (r % 2 == 0) ? j : (LANES - 1 - j);
                        2: rows[r][b][j] = (r % 2 == 0) ? -32768 : -1;
                        default: begin
                            r16 = 16'($urandom);
                            if ($urandom_range(0, 3) == 0) r16 = 16'($urandom_range(0, 7)) - 16'd4;
                            rows[r][b][j] = int'($signed(r16));
                        end
                    endcase
                end
            end
        end

        // Reference: each output is the max of a 2x2 window.
        for (int r = 1; r < nrows; r += 2) begin
            for (int b = 0; b < nb; b++) begin
                g = r * nb + b;
                if (g < limit) begin
                    e.d = '0;
                    for (int k = 0; k < HALF; k++) begin
                        mx = rows[r-1][b][2*k];
                        if (rows[r-1][b][2*k+1] > mx) mx = rows[r-1][b][2*k+1];
                        if (rows[r][b][2*k]     > mx) mx = rows[r][b][2*k];
                        if (rows[r][b][2*k+1]   > mx) mx = rows[r][b][2*k+1];
                        if (relu && mx < 0) mx = 0;
                        e.d[k*DATA_W +: DATA_W] = 16'(mx);
                    end
                    e.l = (g == total - 1);
                    exp_q.push_back(e);
                end
            end
        end

        for (int r = 0; r < nrows; r++) begin
            for (int b = 0; b < nb; b++) begin
                g = r * nb + b;
                if (g < limit) begin
                    for (int j = 0; j < LANES; j++) d[j*DATA_W +: DATA_W] = 16'(rows[r][b][j]);
                    drive_beat(d, (g == total - 1) || (g == bad_last));
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        n_pop      = 0;
        stall_prev = 1'b0;
        held_prev  = '0;
        last_out   = '0;
        cfg_beats  = '0;
        cfg_relu   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;

        // 1: reset and idle
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);

        // 2: single-beat rows, ramp pattern
        run_frame(1, 2, 1'b0, 1, -1, -1);
        drain("t2_drain");
        chk("t2_data", last_out, {16'd11, 16'd9, 16'd7, 16'd7, 16'd9, 16'd11});

        // 3: signed compare, then ReLU
        run_frame(2, 2, 1'b0, 2, -1, -1);
        drain("t3_drain_norelu");
        chk("t3_norelu", last_out, {HALF{16'hFFFF}});
        run_frame(2, 2, 1'b1, 2, -1, -1);
        drain("t3_drain_relu");
        chk("t3_relu", last_out, {HALF{16'h0000}});

        // 4: backpressure on the second ROW_B output
        n_pop = 0;
        fork
            run_frame(4, 2, 1'b0, 0, -1, -1);
            begin
                int guard;
                logic [OUT_W-1:0] held;
                guard = 0;
                while (!(out_valid && n_pop == 1) && guard < 200) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                chk("t4_reach_stall", out_valid && (n_pop == 1), 1);
                out_ready = 1'b0;
                held = out_data;
                repeat (3) begin
                    @(negedge clk);
                    chk("t4_in_ready_stall", in_ready, 0);
                    chk("t4_data_stable", out_data, held);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("t4_drain");
        chk("t4_count", n_pop, 4);

        // 5: multi-pair frame, then a frame with a stray in_last in ROW_A
        n_pop = 0;
        run_frame(3, 4, 1'($urandom_range(0, 1)), 0, -1, -1);
        drain("t5_drain");
        chk("t5_count", n_pop, 6);
        chk("t5_err_clean", err, 0);
        n_pop = 0;
        run_frame(3, 4, 1'b0, 0, 1, -1);
        drain("t5b_drain");
        chk("t5b_count", n_pop, 6);
        chk("t5b_err", err, 1);

        // boundary row lengths: 0 and >MAX_BEATS both mean MAX_BEATS
        run_frame(0, 2, 1'b1, 0, -1, -1);
        drain("cfg0_drain");
        run_frame(12, 2, 1'b0, 0, -1, -1);
        drain("cfg12_drain");

        // 6: reset mid-frame after 2 of 4 ROW_B beats, then a new frame
        do_reset();
        chk("t6_err_cleared", err, 0);
        run_frame(4, 2, 1'b0, 0, -1, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_partial_drained", exp_q.size(), 0);
        do_reset();
        chk("t6_out_valid_rst", out_valid, 0);
        n_pop = 0;
        run_frame(2, 2, 1'b0, 0, -1, -1);
        drain("t6_drain");
        chk("t6_count", n_pop, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
